histogram_ram_scheduler: RTL

//  Owns the 256-bin x 20-bit dual-port histogram RAM and sequences it per frame: CLEAR, ACCUMulate, DRAIN, then DISPLAY.

---
 rtl/histogram_ram_scheduler_pkg.sv | 14 +
 rtl/histogram_ram_scheduler_if.sv | 46 ++++
 rtl/histogram_ram_scheduler_rmw_pipe.sv | 81 ++++++++
 rtl/histogram_ram_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/histogram_ram_scheduler_pkg.sv
// Shared constants and FSM state type for the histogram RAM scheduler.
package histo_pkg;
    localparam int BIN_W_DEF = 8;
    localparam int CNT_W_DEF = 20;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        DISPLAY
    } state_t;
endpackage

// File: rtl/histogram_ram_scheduler_if.sv
// Frame control, pixel stream, display and RAM port bundle for the scheduler.
// Optional HISTO_PEAK_EN adds the peak output used for bar scaling.
interface histogram_ram_scheduler_if #(
    parameter int BIN_W = 8,
    parameter int CNT_W = 20
);
    logic             frame_start;
    logic             frame_end;
    logic             pixel_valid;
    logic [BIN_W-1:0] pixel;
    logic [BIN_W-1:0] disp_addr;
    logic [CNT_W-1:0] disp_value;
    logic             disp_valid;
    logic [BIN_W-1:0] rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             wr_en;
    logic [BIN_W-1:0] wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic             busy;
    logic             dropped;
`ifdef HISTO_PEAK_EN
    logic [CNT_W-1:0] peak;

    modport slave (
        input  frame_start, frame_end, pixel_valid, pixel, disp_addr, rd_data,
        output disp_value, disp_valid, rd_addr, wr_en, wr_addr, wr_data,
               busy, dropped, peak
    );
    modport master (
        output frame_start, frame_end, pixel_valid, pixel, disp_addr, rd_data,
        input  disp_value, disp_valid, rd_addr, wr_en, wr_addr, wr_data,
               busy, dropped, peak
    );
`else
    modport slave (
        input  frame_start, frame_end, pixel_valid, pixel, disp_addr, rd_data,
        output disp_value, disp_valid, rd_addr, wr_en, wr_addr, wr_data,
               busy, dropped
    );
    modport master (
        output frame_start, frame_end, pixel_valid, pixel, disp_addr, rd_data,
        input  disp_value, disp_valid, rd_addr, wr_en, wr_addr, wr_data,
               busy, dropped
    );
`endif
endinterface

// File: rtl/histogram_ram_scheduler_rmw_pipe.sv
// Two-stage read-modify-write for histogram bins with hazard forwarding and
// saturating increment; also carries the clear writes on the same write port.
module histo_rmw_pipe #(
    parameter int BIN_W = 8,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [BIN_W-1:0] in_bin,
    input  logic [CNT_W-1:0] rd_data,
    input  logic             clr_en,
    input  logic [BIN_W-1:0] clr_addr,
    output logic             wr_en,
    output logic [BIN_W-1:0] wr_addr,
    output logic [CNT_W-1:0] wr_data
);
    logic             vld_q;
    logic [BIN_W-1:0] bin_q;
    logic             fwd_vld;
    logic [BIN_W-1:0] fwd_addr;
    logic [CNT_W-1:0] fwd_data;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] sum;

    // rd_data was sampled on the edge that committed fwd_*, so a read-first RAM
    // may have missed that write; the write on the port right now is newer still.
    always_comb begin
        base = rd_data;
        if (fwd_vld && fwd_addr == bin_q)
            base = fwd_data;
        if (wr_en && wr_addr == bin_q)
            base = wr_data;
        sum = (base == '1) ? base : base + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_vld;
        end
        if (!rst_n)
            bin_q <= '0;
        else
            bin_q <= in_bin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (flush) begin
            wr_en <= 1'b0;
        end else if (clr_en) begin
            wr_en   <= 1'b1;
            wr_addr <= clr_addr;
            wr_data <= '0;
        end else begin
            wr_en <= vld_q;
            if (vld_q) begin
                wr_addr <= bin_q;
                wr_data <= sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else begin
            fwd_vld  <= wr_en;
            fwd_addr <= wr_addr;
            fwd_data <= wr_data;
        end
    end
endmodule

// File: rtl/histogram_ram_scheduler.sv
// Per-frame sequencer for the histogram RAM: CLEAR, ACCUM, DRAIN, DISPLAY.
// Define HISTO_PEAK_EN to add the running peak output.
module histogram_ram_scheduler
    import histo_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    histogram_ram_scheduler_if.slave bus
);
    state_t           state, state_nxt;
    logic [BIN_W-1:0] clr_cnt;
    logic             drain_cnt;
    logic [CNT_W-1:0] disp_value;
    logic             dropped;
    logic             pipe_vld;
    logic             clr_en;
    logic             wr_en;
    logic [BIN_W-1:0] wr_addr;
    logic [CNT_W-1:0] wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Every state honours frame_start, so it also takes priority over frame_end.
    always_comb begin
        state_nxt = state;
        pipe_vld  = 1'b0;
        clr_en    = 1'b0;
        unique case (state)
            IDLE:    if (bus.frame_start) state_nxt = CLEAR;
            CLEAR: begin
                clr_en = 1'b1;
                if (bus.frame_start)    state_nxt = CLEAR;
                else if (clr_cnt == '1) state_nxt = ACCUM;
            end
            ACCUM: begin
                pipe_vld = bus.pixel_valid;
                if (bus.frame_start)    state_nxt = CLEAR;
                else if (bus.frame_end) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bus.frame_start)    state_nxt = CLEAR;
                else if (drain_cnt)     state_nxt = DISPLAY;
            end
            DISPLAY: if (bus.frame_start) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (bus.frame_start)
                clr_cnt <= '0;
            else if (state == CLEAR)
                clr_cnt <= clr_cnt + BIN_W'(1);
            drain_cnt <= (state == DRAIN) && !bus.frame_start;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            dropped <= 1'b0;
        else if (bus.frame_start)
            dropped <= 1'b0;
        else if (bus.pixel_valid && state != ACCUM)
            dropped <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            disp_value <= '0;
        else if (state == DISPLAY)
            disp_value <= bus.rd_data;
    end

    histo_rmw_pipe #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_rmw (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.frame_start),
        .in_vld   (pipe_vld),
        .in_bin   (bus.pixel),
        .rd_data  (bus.rd_data),
        .clr_en   (clr_en),
        .clr_addr (clr_cnt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    assign bus.rd_addr    = (state == ACCUM) ? bus.pixel : bus.disp_addr;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.disp_value = disp_value;
    assign bus.disp_valid = (state == DISPLAY);
    assign bus.busy       = (state == CLEAR) || (state == ACCUM) || (state == DRAIN);
    assign bus.dropped    = dropped;

`ifdef HISTO_PEAK_EN
    logic [CNT_W-1:0] peak;

    // Pixel writes finish during DRAIN, so the peak keeps tracking there too.
    always_ff @(posedge clk) begin
        if (!rst_n)
            peak <= '0;
        else if (bus.frame_start)
            peak <= '0;
        else if (wr_en && (state == ACCUM || state == DRAIN) && wr_data > peak)
            peak <= wr_data;
    end

    assign bus.peak = peak;
`endif
endmodule
